// File: rtl/pcr_fetch_gen.sv
// Fetch-PC generator: issues aligned fetch groups to the IFU, takes trap and
// branch redirects (trap wins), tags each group with a redirect epoch, and can
// be parked by a level halt request.
module pcr_fetch_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter int unsigned     FETCH_WIDTH  = 2,
  parameter int unsigned     EPOCH_W      = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   pcr_rx_trap_valid,
  input  logic [XLEN-1:0]        pcr_rx_trap_pc,
  input  logic                   pcr_rx_bc_valid,
  input  logic [XLEN-1:0]        pcr_rx_bc_pc,
  output logic                   pcr_rx_ready,
  input  logic                   pcr_halt,
  output logic                   pcr_tx_valid,
  input  logic                   pcr_tx_ready,
  output logic [XLEN-1:0]        pcr_tx_pc,
  output logic [FETCH_WIDTH-1:0] pcr_tx_mask,
  output logic [EPOCH_W-1:0]     pcr_tx_epoch
);

  // Byte offset bits covered by one fetch group.
  localparam int unsigned     Off        = $clog2(FETCH_WIDTH) + 2;
  localparam logic [XLEN-1:0] AlignMask  = ~((XLEN'(1) << Off) - XLEN'(1));
  localparam logic [XLEN-1:0] GroupBytes = XLEN'(4 * FETCH_WIDTH);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;

  logic                redir;
  logic                hs;
  logic [XLEN-1:0]     target;
  logic [XLEN-1:0]     seq_pc;
  logic [Off-1:0]      slot;

  // Redirect acceptance, target selection and sequential advance.
  always_comb begin
    pcr_rx_ready = rstn;
    // Trap has priority; a simultaneous branch is simply dropped.
    redir        = rstn & (pcr_rx_trap_valid | pcr_rx_bc_valid);
    target       = pcr_rx_trap_valid ? pcr_rx_trap_pc : pcr_rx_bc_pc;
    target[1:0]  = 2'b00;
    pcr_tx_valid = (state_q == StRun);
    hs           = pcr_tx_valid & pcr_tx_ready;
    seq_pc       = (pc_q & AlignMask) + GroupBytes;
  end

  // Next-state, next-PC and epoch update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q + EPOCH_W'(redir);
    case (state_q)
      StBoot: begin
        state_d = StRun;
        pc_d    = redir ? target : RESET_VECTOR;
      end
      StRun: begin
        if (redir) begin
          pc_d = target;
        end else if (hs) begin
          pc_d = seq_pc;
        end
        // Park only once the outstanding group has been taken.
        if (pcr_halt && (!pcr_tx_valid || hs)) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        if (redir) begin
          pc_d = target;
        end
        if (!pcr_halt) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Slot mask: slots before the entry point within the group are invalid.
  always_comb begin
    pcr_tx_mask = '0;
    slot        = pc_q[Off-1:0] >> 2;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      pcr_tx_mask[i] = (Off'(i) >= slot);
    end
  end

  // State, PC and epoch registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StBoot;
      pc_q    <= RESET_VECTOR;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  assign pcr_tx_pc    = pc_q;
  assign pcr_tx_epoch = epoch_q;

endmodule

// File: tb/tb_pcr_fetch_gen.sv
// Directed bench for pcr_fetch_gen (XLEN=32, FETCH_WIDTH=2, EPOCH_W=2).
// Observed vector per cycle: {rx_ready, tx_valid, tx_pc, tx_mask, tx_epoch}.
module tb_pcr_fetch_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pcr_rx_trap_valid;
  logic [31:0] pcr_rx_trap_pc;
  logic        pcr_rx_bc_valid;
  logic [31:0] pcr_rx_bc_pc;
  logic        pcr_rx_ready;
  logic        pcr_halt;
  logic        pcr_tx_valid;
  logic        pcr_tx_ready;
  logic [31:0] pcr_tx_pc;
  logic [1:0]  pcr_tx_mask;
  logic [1:0]  pcr_tx_epoch;

  int checks = 0;
  int passes = 0;

  pcr_fetch_gen #(
    .XLEN        (32),
    .RESET_VECTOR(32'h8000_0000),
    .FETCH_WIDTH (2),
    .EPOCH_W     (2)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .pcr_rx_trap_valid(pcr_rx_trap_valid),
    .pcr_rx_trap_pc   (pcr_rx_trap_pc),
    .pcr_rx_bc_valid  (pcr_rx_bc_valid),
    .pcr_rx_bc_pc     (pcr_rx_bc_pc),
    .pcr_rx_ready     (pcr_rx_ready),
    .pcr_halt         (pcr_halt),
    .pcr_tx_valid     (pcr_tx_valid),
    .pcr_tx_ready     (pcr_tx_ready),
    .pcr_tx_pc        (pcr_tx_pc),
    .pcr_tx_mask      (pcr_tx_mask),
    .pcr_tx_epoch     (pcr_tx_epoch)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] sample();
    return {pcr_rx_ready, pcr_tx_valid, pcr_tx_pc, pcr_tx_mask, pcr_tx_epoch};
  endfunction

  function automatic logic [37:0] vec(input logic rdy, input logic vld, input logic [31:0] pc,
                                      input logic [1:0] mask, input logic [1:0] ep);
    return {rdy, vld, pc, mask, ep};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [37:0] got;
    rstn = 1'b0; pcr_rx_trap_valid = 1'b0; pcr_rx_trap_pc = '0; pcr_rx_bc_valid = 1'b0;
    pcr_rx_bc_pc = '0; pcr_halt = 1'b0; pcr_tx_ready = 1'b0;
    step(); step();
    got = sample();
    checks++;
    if (got !== vec(1'b0, 1'b0, 32'h8000_0000, 2'b11, 2'd0))
      $display("FAIL reset got %h want %h", got, vec(1'b0, 1'b0, 32'h8000_0000, 2'b11, 2'd0));
    else passes++;
  endtask

  // Boot group then sequential advance, then a stalled group must hold.
  task automatic test_sequential();
    logic [37:0] got;
    logic [31:0] exp_pc [4] = '{32'h8000_0000, 32'h8000_0008, 32'h8000_0010, 32'h8000_0010};
    pcr_tx_ready = 1'b1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      got = sample();
      checks++;
      if (got !== vec(1'b1, 1'b1, exp_pc[i], 2'b11, 2'd0))
        $display("FAIL seq[%0d] got %h want %h", i, got, vec(1'b1, 1'b1, exp_pc[i], 2'b11, 2'd0));
      else passes++;
      if (i == 2) pcr_tx_ready = 1'b0;
    end
  endtask

  // Branch redirect overrides a stalled group, mid-group entry gives partial mask.
  task automatic test_branch_redirect();
    logic [37:0] got;
    pcr_rx_bc_valid = 1'b1; pcr_rx_bc_pc = 32'h8000_0104;
    step();
    pcr_rx_bc_valid = 1'b0;
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'h8000_0104, 2'b10, 2'd1))
      $display("FAIL bc_redirect got %h want %h", got, vec(1'b1, 1'b1, 32'h8000_0104, 2'b10, 2'd1));
    else passes++;
    pcr_tx_ready = 1'b1;
    step();
    pcr_tx_ready = 1'b0;
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'h8000_0108, 2'b11, 2'd1))
      $display("FAIL bc_seq got %h want %h", got, vec(1'b1, 1'b1, 32'h8000_0108, 2'b11, 2'd1));
    else passes++;
  endtask

  // Trap beats branch in the same cycle; target low bits are cleared.
  task automatic test_trap_priority();
    logic [37:0] got;
    pcr_rx_trap_valid = 1'b1; pcr_rx_trap_pc = 32'h8000_0203;
    pcr_rx_bc_valid = 1'b1;   pcr_rx_bc_pc = 32'h8000_0300;
    step();
    pcr_rx_trap_valid = 1'b0; pcr_rx_bc_valid = 1'b0;
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'h8000_0200, 2'b11, 2'd2))
      $display("FAIL trap_prio got %h want %h", got, vec(1'b1, 1'b1, 32'h8000_0200, 2'b11, 2'd2));
    else passes++;
    step();
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'h8000_0200, 2'b11, 2'd2))
      $display("FAIL trap_hold got %h want %h", got, vec(1'b1, 1'b1, 32'h8000_0200, 2'b11, 2'd2));
    else passes++;
  endtask

  // PC wraps at the top of the address space; epoch wraps 3 -> 0.
  task automatic test_wrap();
    logic [37:0] got;
    pcr_rx_bc_valid = 1'b1; pcr_rx_bc_pc = 32'hFFFF_FFF8;
    step();
    pcr_rx_bc_valid = 1'b0;
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'hFFFF_FFF8, 2'b11, 2'd3))
      $display("FAIL wrap_tgt got %h want %h", got, vec(1'b1, 1'b1, 32'hFFFF_FFF8, 2'b11, 2'd3));
    else passes++;
    pcr_tx_ready = 1'b1;
    step();
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'h0000_0000, 2'b11, 2'd3))
      $display("FAIL pc_wrap got %h want %h", got, vec(1'b1, 1'b1, 32'h0000_0000, 2'b11, 2'd3));
    else passes++;
    // Redirect together with a handshake: target wins over sequential PC.
    pcr_rx_bc_valid = 1'b1; pcr_rx_bc_pc = 32'h8000_0008;
    step();
    pcr_rx_bc_valid = 1'b0;
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'h8000_0008, 2'b11, 2'd0))
      $display("FAIL epoch_wrap got %h want %h", got, vec(1'b1, 1'b1, 32'h8000_0008, 2'b11, 2'd0));
    else passes++;
  endtask

  // Halt after the group at 0x8000_0010 is taken; redirect while halted.
  task automatic test_halt();
    logic [37:0] got;
    step();
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'h8000_0010, 2'b11, 2'd0))
      $display("FAIL pre_halt got %h want %h", got, vec(1'b1, 1'b1, 32'h8000_0010, 2'b11, 2'd0));
    else passes++;
    pcr_halt = 1'b1;
    step();
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b0, 32'h8000_0018, 2'b11, 2'd0))
      $display("FAIL halt_enter got %h want %h", got, vec(1'b1, 1'b0, 32'h8000_0018, 2'b11, 2'd0));
    else passes++;
    pcr_tx_ready = 1'b0;
    pcr_rx_bc_valid = 1'b1; pcr_rx_bc_pc = 32'h8000_0400;
    step();
    pcr_rx_bc_valid = 1'b0;
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b0, 32'h8000_0400, 2'b11, 2'd1))
      $display("FAIL halt_redir got %h want %h", got, vec(1'b1, 1'b0, 32'h8000_0400, 2'b11, 2'd1));
    else passes++;
    step();
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b0, 32'h8000_0400, 2'b11, 2'd1))
      $display("FAIL halt_stay got %h want %h", got, vec(1'b1, 1'b0, 32'h8000_0400, 2'b11, 2'd1));
    else passes++;
    pcr_halt = 1'b0;
    step();
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'h8000_0400, 2'b11, 2'd1))
      $display("FAIL halt_exit got %h want %h", got, vec(1'b1, 1'b1, 32'h8000_0400, 2'b11, 2'd1));
    else passes++;
  endtask

  // Reset mid-stall clears everything at once; a trap on the boot edge wins.
  task automatic test_mid_reset();
    logic [37:0] got;
    pcr_rx_bc_valid = 1'b1; pcr_rx_bc_pc = 32'h8000_0050;
    step();
    pcr_rx_bc_valid = 1'b0;
    step();
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'h8000_0050, 2'b11, 2'd2))
      $display("FAIL stall_50 got %h want %h", got, vec(1'b1, 1'b1, 32'h8000_0050, 2'b11, 2'd2));
    else passes++;
    rstn = 1'b0;
    #1;
    got = sample();
    checks++;
    if (got !== vec(1'b0, 1'b0, 32'h8000_0000, 2'b11, 2'd0))
      $display("FAIL async_rst got %h want %h", got, vec(1'b0, 1'b0, 32'h8000_0000, 2'b11, 2'd0));
    else passes++;
    // Redirect requests during reset must not be taken.
    pcr_rx_bc_valid = 1'b1; pcr_rx_bc_pc = 32'h8000_0700;
    step();
    got = sample();
    checks++;
    if (got !== vec(1'b0, 1'b0, 32'h8000_0000, 2'b11, 2'd0))
      $display("FAIL rst_hold got %h want %h", got, vec(1'b0, 1'b0, 32'h8000_0000, 2'b11, 2'd0));
    else passes++;
    pcr_rx_bc_valid = 1'b0;
    pcr_rx_trap_valid = 1'b1; pcr_rx_trap_pc = 32'h8000_0304;
    rstn = 1'b1;
    step();
    pcr_rx_trap_valid = 1'b0;
    got = sample();
    checks++;
    if (got !== vec(1'b1, 1'b1, 32'h8000_0304, 2'b10, 2'd1))
      $display("FAIL boot_redir got %h want %h", got, vec(1'b1, 1'b1, 32'h8000_0304, 2'b10, 2'd1));
    else passes++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_redirect();
    test_trap_priority();
    test_wrap();
    test_halt();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
